// File: rtl/dscope_pkg.sv
// Shared types and constants for the digital-scope capture core.
package dscope_pkg;

  typedef enum logic [1:0] {StFill, StArmed, StPost, StRead} state_e;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MISS_W      = 8;

endpackage

// File: rtl/dscope_ring_ram.sv
// Simple dual-port sample ring: one write port, one registered read port.
module dscope_ring_ram #(
  parameter int unsigned Width = 20,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [2**AddrW];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dscope_capture.sv
// Multi-channel capture: circular pre-trigger history, post-trigger window, then
// channel-interleaved readout under ready/valid backpressure.
module dscope_capture
  import dscope_pkg::*;
#(
  parameter int unsigned CH_NUM = 2,
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEC_W  = 8
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     i_sync,
  input  logic                     i_smp_vld,
  input  logic [CH_NUM*DATA_W-1:0] i_smp_data,
  input  logic [ADDR_W-1:0]        i_pre_len,
  input  logic [ADDR_W-1:0]        i_post_len,
  input  logic [DEC_W-1:0]         i_decim,
  output logic [DATA_W-1:0]        o_out_data,
  output logic                     o_out_vld,
  input  logic                     i_out_rdy,
  output logic                     o_out_sop,
  output logic                     o_out_eop,
  output logic                     o_busy,
  output logic [MISS_W-1:0]        o_trig_miss
);

  localparam int unsigned LineW = CH_NUM * DATA_W;
  localparam int unsigned ChW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [ADDR_W:0]  Depth  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ChW-1:0]   LastCh = ChW'(CH_NUM - 1);

  state_e                 state_q, state_d;
  logic                   load_q, load_d;
  logic [ADDR_W-1:0]      pre_q, pre_d, post_q, post_d;
  logic [DEC_W-1:0]       decim_q, decim_d, dec_cnt_q, dec_cnt_d;
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d, trig_addr_q, trig_addr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        fill_cnt_q, fill_cnt_d, post_cnt_q, post_cnt_d, iss_cnt_q, iss_cnt_d;
  logic [ChW-1:0]         iss_ch_q, iss_ch_d, p1_ch_q, p1_ch_d;
  logic                   p1_vld_q, p1_vld_d, p1_sop_q, p1_sop_d, p1_eop_q, p1_eop_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic                   out_vld_q, out_vld_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic                   skid_vld_q, skid_vld_d, skid_sop_q, skid_sop_d, skid_eop_q, skid_eop_d;
  logic [MISS_W-1:0]      miss_q, miss_d;
  logic                   busy_q, busy_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;

  logic                   trig, store, issue, pop, can_issue;
  logic [1:0]             occ;
  logic [ADDR_W:0]        post_raw, len_sum, frame_len;
  logic [ADDR_W-1:0]      post_clamp;
  logic [LineW-1:0]       ram_rdata;
  logic [DATA_W-1:0]      word_in;

  dscope_ring_ram #(
    .Width (LineW),
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (sys_clk),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_smp_data),
    .re_i    (issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // A zero post length means one sample; the frame may never exceed the ring.
  always_comb begin
    post_raw   = (i_post_len == '0) ? {{ADDR_W{1'b0}}, 1'b1} : {1'b0, i_post_len};
    len_sum    = {1'b0, i_pre_len} + post_raw;
    post_clamp = (len_sum > Depth) ? ADDR_W'(Depth - {1'b0, i_pre_len})
                                   : post_raw[ADDR_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    pre_d       = pre_q;
    post_d      = post_q;
    decim_d     = decim_q;
    dec_cnt_d   = dec_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    iss_cnt_d   = iss_cnt_q;
    iss_ch_d    = iss_ch_q;
    miss_d      = miss_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_sop_d  = skid_sop_q;
    skid_eop_d  = skid_eop_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    sync_d      = {sync_q[SYNC_STAGES-2:0], i_sync};
    sync_prev_d = sync_q[SYNC_STAGES-1];
    trig        = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

    frame_len = {1'b0, pre_q} + {1'b0, post_q};
    store     = i_smp_vld && (dec_cnt_q == '0) && (state_q != StRead);
    pop       = out_vld_q & i_out_rdy;
    occ       = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, p1_vld_q};
    // Output reg + skid hold two words; the word in flight from the RAM claims one.
    can_issue = (occ - {1'b0, pop}) <= 2'd1;
    issue     = (state_q == StRead) && (iss_cnt_q < frame_len) && can_issue;
    word_in   = ram_rdata[DATA_W*int'(p1_ch_q) +: DATA_W];

    p1_vld_d = issue;
    p1_ch_d  = iss_ch_q;
    p1_sop_d = (iss_cnt_q == '0) && (iss_ch_q == '0);
    p1_eop_d = (iss_cnt_q == frame_len - 1'b1) && (iss_ch_q == LastCh);

    if (trig && (state_q != StArmed) && (miss_q != '1)) miss_d = miss_q + 1'b1;
    if (i_smp_vld && (state_q != StRead)) begin
      dec_cnt_d = (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + 1'b1;
    end
    if (store) wr_ptr_d = wr_ptr_q + 1'b1;

    unique case (state_q)
      StFill: begin
        fill_cnt_d = fill_cnt_q + {{ADDR_W{1'b0}}, store};
        if (load_q) begin
          load_d  = 1'b0;
          pre_d   = i_pre_len;
          post_d  = post_clamp;
          decim_d = i_decim;
        end else if (fill_cnt_q >= {1'b0, pre_q}) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (trig) begin
          trig_addr_d = wr_ptr_d;
          post_cnt_d  = '0;
          state_d     = StPost;
        end
      end
      StPost: begin
        if (store) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_d == {1'b0, post_q}) begin
            rd_ptr_d  = trig_addr_q - pre_q;
            iss_cnt_d = '0;
            iss_ch_d  = '0;
            state_d   = StRead;
          end
        end
      end
      StRead: begin
        if (issue) begin
          if (iss_ch_q == LastCh) begin
            iss_ch_d  = '0;
            iss_cnt_d = iss_cnt_q + 1'b1;
            rd_ptr_d  = rd_ptr_q + 1'b1;
          end else begin
            iss_ch_d = iss_ch_q + 1'b1;
          end
        end
        if (pop && out_eop_q) begin
          state_d    = StFill;
          load_d     = 1'b1;
          fill_cnt_d = '0;
          dec_cnt_d  = '0;
        end
      end
      default: state_d = StFill;
    endcase

    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_data_d  = skid_data_q;
        out_sop_d   = skid_sop_q;
        out_eop_d   = skid_eop_q;
        skid_vld_d  = p1_vld_q;
        skid_data_d = word_in;
        skid_sop_d  = p1_sop_q;
        skid_eop_d  = p1_eop_q;
      end else begin
        out_vld_d = p1_vld_q;
        out_sop_d = p1_vld_q & p1_sop_q;
        out_eop_d = p1_vld_q & p1_eop_q;
        if (p1_vld_q) out_data_d = word_in;
      end
    end else if (p1_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_data_d = word_in;
      skid_sop_d  = p1_sop_q;
      skid_eop_d  = p1_eop_q;
    end

    busy_d = (state_d == StPost) || (state_d == StRead);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      load_q      <= 1'b1;
      pre_q       <= '0;
      post_q      <= '0;
      decim_q     <= '0;
      dec_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      rd_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      iss_cnt_q   <= '0;
      iss_ch_q    <= '0;
      p1_vld_q    <= 1'b0;
      p1_ch_q     <= '0;
      p1_sop_q    <= 1'b0;
      p1_eop_q    <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sop_q  <= 1'b0;
      skid_eop_q  <= 1'b0;
      miss_q      <= '0;
      busy_q      <= 1'b0;
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      decim_q     <= decim_d;
      dec_cnt_q   <= dec_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      iss_cnt_q   <= iss_cnt_d;
      iss_ch_q    <= iss_ch_d;
      p1_vld_q    <= p1_vld_d;
      p1_ch_q     <= p1_ch_d;
      p1_sop_q    <= p1_sop_d;
      p1_eop_q    <= p1_eop_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_sop_q  <= skid_sop_d;
      skid_eop_q  <= skid_eop_d;
      miss_q      <= miss_d;
      busy_q      <= busy_d;
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
    end
  end

  assign o_out_data  = out_data_q;
  assign o_out_vld   = out_vld_q;
  assign o_out_sop   = out_sop_q;
  assign o_out_eop   = out_eop_q;
  assign o_busy      = busy_q;
  assign o_trig_miss = miss_q;

endmodule

// File: tb/tb_dscope_capture.sv
// Scoreboard bench for dscope_capture: directed frames with a reference model of
// which ramp samples land in each frame.
module tb_dscope_capture;

  localparam int unsigned CH_NUM = 2;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEC_W  = 8;
  localparam int          DEPTH  = 16;

  logic                     sys_clk;
  logic                     rst_n;
  logic                     i_sync;
  logic                     i_smp_vld;
  logic [CH_NUM*DATA_W-1:0] i_smp_data;
  logic [ADDR_W-1:0]        i_pre_len;
  logic [ADDR_W-1:0]        i_post_len;
  logic [DEC_W-1:0]         i_decim;
  logic [DATA_W-1:0]        o_out_data;
  logic                     o_out_vld;
  logic                     i_out_rdy;
  logic                     o_out_sop;
  logic                     o_out_eop;
  logic                     o_busy;
  logic [7:0]               o_trig_miss;

  dscope_capture #(
    .CH_NUM (CH_NUM),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEC_W  (DEC_W)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .i_sync      (i_sync),
    .i_smp_vld   (i_smp_vld),
    .i_smp_data  (i_smp_data),
    .i_pre_len   (i_pre_len),
    .i_post_len  (i_post_len),
    .i_decim     (i_decim),
    .o_out_data  (o_out_data),
    .o_out_vld   (o_out_vld),
    .i_out_rdy   (i_out_rdy),
    .o_out_sop   (o_out_sop),
    .o_out_eop   (o_out_eop),
    .o_busy      (o_busy),
    .o_trig_miss (o_trig_miss)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   rdy_mode = 0;
  int   rcnt = 0;
  bit   prev_stall = 0;
  logic [DATA_W-1:0] prev_data;
  logic prev_sop, prev_eop;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Ready pattern: 0 = always ready, 1 = alternate 1/0 with a 3-cycle low burst.
  initial begin
    i_out_rdy = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      rcnt++;
      if (rdy_mode == 0) i_out_rdy = 1'b1;
      else if ((rcnt % 40) >= 20 && (rcnt % 40) < 23) i_out_rdy = 1'b0;
      else i_out_rdy = (rcnt % 2) == 1;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks hold during stalls.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!o_out_vld || o_out_data != prev_data || o_out_sop != prev_sop
              || o_out_eop != prev_eop) begin
            errors++;
            $display("FAIL hold: got vld=%0b data=%0d sop=%0b eop=%0b, required vld=1 data=%0d sop=%0b eop=%0b",
                     o_out_vld, o_out_data, o_out_sop, o_out_eop, prev_data, prev_sop, prev_eop);
          end
        end
        if (o_out_vld && i_out_rdy) begin
          hs_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_word: got data=%0d sop=%0b eop=%0b, required no word",
                     o_out_data, o_out_sop, o_out_eop);
          end else begin
            mon_e = exp_q.pop_front();
            if (o_out_data != mon_e.data || o_out_sop != mon_e.sop || o_out_eop != mon_e.eop) begin
              errors++;
              $display("FAIL word: got data=%0d sop=%0b eop=%0b, required data=%0d sop=%0b eop=%0b",
                       o_out_data, o_out_sop, o_out_eop, mon_e.data, mon_e.sop, mon_e.eop);
            end
          end
        end
        prev_stall = o_out_vld && !i_out_rdy;
        prev_data  = o_out_data;
        prev_sop   = o_out_sop;
        prev_eop   = o_out_eop;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic do_reset(input int pre, input int post, input int decim);
    i_pre_len  = ADDR_W'(pre);
    i_post_len = ADDR_W'(post);
    i_decim    = DEC_W'(decim);
    i_sync     = 1'b0;
    i_smp_vld  = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);
  endtask

  // Reference: ramp value n is strobe n; stored values are multiples of (decim+1).
  task automatic build_frame(input int pre, input int post, input int decim, input int s,
                             output int last);
    int   k, pe, t, first;
    exp_t e;
    k  = decim + 1;
    pe = (post == 0) ? 1 : post;
    if (pre + pe > DEPTH) pe = DEPTH - pre;
    t     = (s / k + 1) * k;
    first = t - pre * k;
    last  = t + (pe - 1) * k;
    for (int v = first; v <= last; v += k) begin
      e.data = DATA_W'(v);
      e.sop  = (v == first);
      e.eop  = 1'b0;
      exp_q.push_back(e);
      e.data = DATA_W'(1000 + v);
      e.sop  = 1'b0;
      e.eop  = (v == last);
      exp_q.push_back(e);
    end
  endtask

  task automatic strobe(input int n, input bit sync);
    @(posedge sys_clk);
    #1;
    i_sync     = 1'b0;
    i_smp_vld  = 1'b1;
    i_smp_data = {DATA_W'(1000 + n), DATA_W'(n)};
    @(posedge sys_clk);
    #1;
    i_smp_vld = 1'b0;
    if (sync) i_sync = 1'b1;
    repeat (4) @(posedge sys_clk);
  endtask

  task automatic stream(input int last, input int s1, input int s2);
    for (int n = 0; n <= last; n++) strobe(n, (n == s1) || (n == s2));
    #1 i_sync = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge sys_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d words pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge sys_clk);
    #1 chk({name, "_busy_idle"}, int'(o_busy), 0);
  endtask

  int last;
  int n;
  int target;

  initial begin
    i_smp_data = '0;
    rst_n      = 1'b0;
    i_sync     = 1'b0;
    i_smp_vld  = 1'b0;
    i_pre_len  = 4'd4;
    i_post_len = 4'd4;
    i_decim    = '0;
    #12;
    chk("rst_vld", int'(o_out_vld), 0);
    chk("rst_sop", int'(o_out_sop), 0);
    chk("rst_eop", int'(o_out_eop), 0);
    chk("rst_data", int'(o_out_data), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_miss", int'(o_trig_miss), 0);

    // Basic frame: 17..24 interleaved with 1017..1024.
    rdy_mode = 0;
    do_reset(4, 4, 0);
    build_frame(4, 4, 0, 20, last);
    stream(last, 20, -1);
    chk("basic_busy_read", int'(o_busy), 1);
    wait_done("basic");
    chk("basic_miss", int'(o_trig_miss), 0);

    // Same frame under toggling ready with a low burst.
    rdy_mode = 1;
    do_reset(4, 4, 0);
    build_frame(4, 4, 0, 20, last);
    stream(last, 20, -1);
    wait_done("bp");

    // Decimation by 4: 16,20,24,28.
    rdy_mode = 0;
    do_reset(2, 2, 3);
    build_frame(2, 2, 3, 20, last);
    stream(last, 20, -1);
    wait_done("decim");

    // Early sync during fill and late sync during readout are both missed.
    rdy_mode = 1;
    do_reset(4, 4, 0);
    build_frame(4, 4, 0, 20, last);
    stream(last, 1, 20);
    n = 0;
    while (!o_out_vld && n < 200) begin
      @(posedge sys_clk);
      n++;
    end
    chk("late_in_read", int'(o_busy), 1);
    @(posedge sys_clk);
    #1 i_sync = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1 i_sync = 1'b0;
    wait_done("miss");
    chk("miss_count", int'(o_trig_miss), 2);
    repeat (60) @(posedge sys_clk);
    #1 chk("miss_one_frame", int'(o_busy), 0);

    // Wrap: trigger at wr_ptr=3, reads 13..15 then 0..10.
    rdy_mode = 0;
    do_reset(6, 8, 0);
    build_frame(6, 8, 0, 18, last);
    stream(last, 18, -1);
    wait_done("wrap");

    // Clamp: pre=10, post=10 becomes post=6, 32 words.
    do_reset(10, 10, 0);
    build_frame(10, 10, 0, 20, last);
    chk("clamp_words", exp_q.size(), 32);
    stream(last, 20, -1);
    wait_done("clamp");

    // Reset after word 5 of a readout, then a full fresh frame.
    do_reset(4, 4, 0);
    build_frame(4, 4, 0, 20, last);
    target = hs_cnt + 6;
    stream(last, 20, -1);
    n = 0;
    while (hs_cnt < target && n < 500) begin
      @(negedge sys_clk);
      #2;
      n++;
    end
    chk("midrst_reached_word5", int'(hs_cnt >= target), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", int'(o_out_vld), 0);
    chk("midrst_busy", int'(o_busy), 0);
    exp_q.delete();
    do_reset(4, 4, 0);
    build_frame(4, 4, 0, 20, last);
    stream(last, 20, -1);
    wait_done("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
